// File: rtl/health_tracker.sv
// Per-fencer health state machine: sword hits -> 3-bit health for the health bar.
// Optional regeneration is built only when HEALTH_REGEN_EN is defined.
module health_tracker #(
  parameter int MAX_HEALTH    = 5,
  parameter int INVULN_FRAMES = 30
`ifdef HEALTH_REGEN_EN
  , parameter int REGEN_FRAMES = 120
`endif
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_frame_in,
  input  logic       round_start_in,
  input  logic       hit_in,
  input  logic [2:0] damage_in,
  output logic [2:0] health_out,
  output logic       invuln_out,
  output logic       dead_out,
  output logic       hit_ack_out
);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  localparam logic [2:0] FULL_HEALTH = 3'(MAX_HEALTH);
  localparam logic [7:0] INV_LOAD    = 8'(INVULN_FRAMES);

  state_t     state, state_nxt;
  logic [2:0] health_nxt;
  logic [7:0] inv_cnt, inv_cnt_nxt;
  logic       ack_nxt;

`ifdef HEALTH_REGEN_EN
  // The counter only ever holds 0..REGEN_FRAMES-1; the last frame produces the tick.
  localparam logic [9:0] REGEN_LAST = 10'(REGEN_FRAMES - 1);
  logic [9:0] regen_cnt, regen_cnt_nxt;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ALIVE;
      health_out  <= FULL_HEALTH;
      inv_cnt     <= '0;
      hit_ack_out <= 1'b0;
      invuln_out  <= 1'b0;
      dead_out    <= 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_cnt   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      health_out  <= health_nxt;
      inv_cnt     <= inv_cnt_nxt;
      hit_ack_out <= ack_nxt;
      invuln_out  <= (state_nxt == INVULN);
      dead_out    <= (state_nxt == DEAD);
`ifdef HEALTH_REGEN_EN
      regen_cnt   <= regen_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    health_nxt  = health_out;
    inv_cnt_nxt = inv_cnt;
    ack_nxt     = 1'b0;
`ifdef HEALTH_REGEN_EN
    regen_cnt_nxt = regen_cnt;
`endif
    // Round restart overrides everything, including a hit in the same cycle.
    if (round_start_in) begin
      state_nxt   = ALIVE;
      health_nxt  = FULL_HEALTH;
      inv_cnt_nxt = '0;
`ifdef HEALTH_REGEN_EN
      regen_cnt_nxt = '0;
`endif
    end else begin
      case (state)
        ALIVE: begin
          if (hit_in && (damage_in != 3'd0)) begin
            ack_nxt = 1'b1;
`ifdef HEALTH_REGEN_EN
            regen_cnt_nxt = '0;
`endif
            if (damage_in >= health_out) begin
              health_nxt  = '0;
              inv_cnt_nxt = '0;
              state_nxt   = DEAD;
            end else begin
              health_nxt  = health_out - damage_in;
              inv_cnt_nxt = INV_LOAD;
              state_nxt   = INVULN;
            end
          end
`ifdef HEALTH_REGEN_EN
          else if (new_frame_in && (health_out < FULL_HEALTH)) begin
            if (regen_cnt == REGEN_LAST) begin
              health_nxt    = health_out + 3'd1;
              regen_cnt_nxt = '0;
            end else begin
              regen_cnt_nxt = regen_cnt + 10'd1;
            end
          end
`endif
        end
        INVULN: begin
          if (new_frame_in) begin
            if (inv_cnt <= 8'd1) begin
              inv_cnt_nxt = '0;
              state_nxt   = ALIVE;
            end else begin
              inv_cnt_nxt = inv_cnt - 8'd1;
            end
          end
        end
        DEAD: begin
          health_nxt = '0;
        end
        default: begin
          state_nxt = ALIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_health_tracker.sv
// Scoreboard bench for health_tracker (MAX_HEALTH=5, INVULN_FRAMES=30, REGEN_FRAMES=4).
// Expected words are {health, invuln, dead, ack}; stimulus words are {round_start, frame, hit, damage}.
module tb_health_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_frame;
  logic       round_start;
  logic       hit;
  logic [2:0] damage;
  logic [2:0] health;
  logic       invuln;
  logic       dead;
  logic       hit_ack;
  logic [5:0] obs;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

`ifdef HEALTH_REGEN_EN
  localparam bit REGEN_ON = 1'b1;
`else
  localparam bit REGEN_ON = 1'b0;
`endif

  health_tracker #(
    .MAX_HEALTH(5),
    .INVULN_FRAMES(30)
`ifdef HEALTH_REGEN_EN
    , .REGEN_FRAMES(4)
`endif
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .new_frame_in(new_frame),
    .round_start_in(round_start),
    .hit_in(hit),
    .damage_in(damage),
    .health_out(health),
    .invuln_out(invuln),
    .dead_out(dead),
    .hit_ack_out(hit_ack)
  );

  assign obs = {health, invuln, dead, hit_ack};

  always #5 clk = ~clk;

  function automatic logic [5:0] stim_word(input logic rs, input logic nf, input logic h, input int d);
    return {rs, nf, h, 3'(d)};
  endfunction

  function automatic logic [5:0] exp_word(input int h, input logic inv, input logic dd, input logic ack);
    return {3'(h), inv, dd, ack};
  endfunction

  task automatic drive_cycle(input logic [5:0] s);
    {round_start, new_frame, hit, damage} = s;
    @(posedge clk);
    #1;
    {round_start, new_frame, hit, damage} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {round_start, new_frame, hit, damage} = '0;
    #2;
    checks++;
    if (obs !== exp_word(5, 0, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_async: got h/inv/dead/ack=%0d/%b/%b/%b expected 5/0/0/0", health, invuln, dead, hit_ack);
    end
    hit = 1'b1;
    damage = 3'd2;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_word(5, 0, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_hold: got h/inv/dead/ack=%0d/%b/%b/%b expected 5/0/0/0", health, invuln, dead, hit_ack);
    end
    hit = 1'b0;
    damage = 3'd0;
    rst = 1'b0;
  endtask

  task automatic test_hit_invuln();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim.push_back(stim_word(0, 0, 1, 2)); expv.push_back(exp_word(3, 1, 0, 1));
    stim.push_back(stim_word(0, 0, 0, 0)); expv.push_back(exp_word(3, 1, 0, 0));
    stim.push_back(stim_word(0, 0, 1, 1)); expv.push_back(exp_word(3, 1, 0, 0));
    for (int k = 0; k < 29; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(3, 1, 0, 0));
    end
    stim.push_back(stim_word(0, 1, 1, 1)); expv.push_back(exp_word(3, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 0, 0)); expv.push_back(exp_word(3, 0, 0, 0));
    for (int i = 0; i < stim.size(); i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL hit_invuln[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_lethal();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim.push_back(stim_word(0, 0, 1, 1)); expv.push_back(exp_word(2, 1, 0, 1));
    for (int k = 0; k < 29; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(2, 1, 0, 0));
    end
    stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(2, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 1, 7)); expv.push_back(exp_word(0, 0, 1, 1));
    stim.push_back(stim_word(0, 0, 0, 0)); expv.push_back(exp_word(0, 0, 1, 0));
    stim.push_back(stim_word(0, 0, 1, 3)); expv.push_back(exp_word(0, 0, 1, 0));
    stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(0, 0, 1, 0));
    stim.push_back(stim_word(1, 0, 0, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    for (int i = 0; i < stim.size(); i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL lethal[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_hit_with_frame();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim.push_back(stim_word(0, 1, 1, 1)); expv.push_back(exp_word(4, 1, 0, 1));
    for (int k = 0; k < 29; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(4, 1, 0, 0));
    end
    stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(4, 0, 0, 0));
    for (int i = 0; i < stim.size(); i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL hit_with_frame[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_round_start_priority();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    stim.push_back(stim_word(1, 0, 0, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 1, 1)); expv.push_back(exp_word(4, 1, 0, 1));
    stim.push_back(stim_word(1, 0, 1, 3)); expv.push_back(exp_word(5, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 0, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 1, 2)); expv.push_back(exp_word(3, 1, 0, 1));
    stim.push_back(stim_word(1, 0, 0, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    stim.push_back(stim_word(0, 0, 1, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    stim.push_back(stim_word(0, 1, 1, 0)); expv.push_back(exp_word(5, 0, 0, 0));
    for (int i = 0; i < stim.size(); i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL round_start_zero_dmg[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Phase 0 resets mid-INVULN, phase 1 mid-DEAD (damage equal to health is lethal).
  task automatic test_async_reset();
    logic [5:0] e;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(p == 0 ? exp_word(1, 1, 0, 1) : exp_word(0, 0, 1, 1));
      drive_cycle(stim_word(0, 0, 1, p == 0 ? 4 : 5));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL async_reset_setup[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 p, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== exp_word(5, 0, 0, 0)) begin
        errors++;
        $display("[TB] FAIL async_reset[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected 5/0/0/0",
                 p, health, invuln, dead, hit_ack);
      end
      #2;
      rst = 1'b0;
    end
  endtask

  task automatic test_regen();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    logic [5:0] e;
    int h;
    int base;
    stim.push_back(stim_word(0, 0, 1, 2)); expv.push_back(exp_word(3, 1, 0, 1));
    for (int k = 0; k < 29; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(3, 1, 0, 0));
    end
    stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(3, 0, 0, 0));
    for (int k = 1; k <= 12; k++) begin
      h = !REGEN_ON ? 3 : (k >= 8 ? 5 : (k >= 4 ? 4 : 3));
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(h, 0, 0, 0));
    end
    base = REGEN_ON ? 5 : 3;
    stim.push_back(stim_word(0, 0, 1, 1)); expv.push_back(exp_word(base - 1, 1, 0, 1));
    for (int k = 0; k < 29; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(base - 1, 1, 0, 0));
    end
    for (int k = 0; k < 4; k++) begin
      stim.push_back(stim_word(0, 1, 0, 0)); expv.push_back(exp_word(base - 1, 0, 0, 0));
    end
    stim.push_back(stim_word(0, 1, 1, 1)); expv.push_back(exp_word(base - 2, 1, 0, 1));
    for (int i = 0; i < stim.size(); i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL regen[%0d]: got h/inv/dead/ack=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, health, invuln, dead, hit_ack, e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    $display("[TB] health_tracker bench, regen build=%0d", REGEN_ON);
    test_reset();
    test_hit_invuln();
    test_lethal();
    test_hit_with_frame();
    test_round_start_priority();
    test_async_reset();
    test_regen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached with %0d checks done", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
